// File: rtl/shift_in_pkg.sv
// Shared types and helpers for the shift-in deserializer.
//   bit_order_e : which end of the word the first received bit lands in
//   cnt_w()     : width of the in-word bit counter for a given word width
package shift_in_pkg;

    typedef enum bit {
        ORDER_MSB_FIRST = 1'b0,
        ORDER_LSB_FIRST = 1'b1
    } bit_order_e;

    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/shift_reg_core.sv
// Enable-gated shift register with selectable shift direction.
// Ports:
//   clk, rst : clock, async active-high reset (clears q)
//   en       : shift one bit in on this edge
//   d        : serial bit
//   q        : current contents
//   q_next   : value q takes on the next edge (lets the owner capture a
//              completed word without waiting a cycle)
module shift_reg_core
    import shift_in_pkg::*;
#(
    parameter int         WIDTH = 8,
    parameter bit_order_e ORDER = ORDER_LSB_FIRST
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH-1:0] shifted;

    // LSB-first: new bits enter at the top and walk down, so the first bit
    // of a word ends at bit 0. MSB-first: new bits enter at bit 0.
    generate
        if (ORDER == ORDER_LSB_FIRST) begin : g_lsb
            assign shifted = {d, q[WIDTH-1:1]};
        end else begin : g_msb
            assign shifted = {q[WIDTH-2:0], d};
        end
    endgenerate

    always_comb begin
        q_next = en ? shifted : q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= '0;
        else     q <= q_next;
    end

endmodule

// File: rtl/shift_in_deser.sv
// Serial-to-parallel deserializer with valid/ready output, frame sync and
// sticky overrun.
// Ports:
//   clk, rst   : clock, async active-high reset
//   in, in_en  : serial bit and its strobe
//   sync       : frame start, realigns the bit counter
//   out        : held word, out_valid/out_ready handshake
//   raw        : live shift register (same bit order as out)
//   bit_cnt    : bits collected in the current partial word
//   overrun    : sticky, a completed word was dropped; clr_ovr clears it
module shift_in_deser
    import shift_in_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in,
    input  logic                      in_en,
    input  logic                      sync,
    output logic [WIDTH-1:0]          out,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          raw,
    output logic [cnt_w(WIDTH)-1:0]   bit_cnt,
    output logic                      overrun,
    input  logic                      clr_ovr
);

    localparam int         CW    = cnt_w(WIDTH);
    localparam bit_order_e ORDER = bit_order_e'(LSB_FIRST);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] raw_next;
    logic             word_done;
    logic             slot_free;

    shift_reg_core #(
        .WIDTH (WIDTH),
        .ORDER (ORDER)
    ) u_sr (
        .clk    (clk),
        .rst    (rst),
        .en     (in_en),
        .d      (in),
        .q      (raw),
        .q_next (raw_next)
    );

    // A sync bit always starts a new frame, so it can never finish one.
    assign word_done = in_en && !sync && (bit_cnt == LAST);
    // The slot is free if empty, or if the consumer drains it on this edge.
    assign slot_free = !out_valid || out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt <= '0;
        end else if (sync) begin
            bit_cnt <= in_en ? CW'(1) : '0;
        end else if (in_en) begin
            bit_cnt <= word_done ? '0 : bit_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else if (word_done && slot_free) begin
            out       <= raw_next;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Setting beats clearing when both land on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                         overrun <= 1'b0;
        else if (word_done && !slot_free) overrun <= 1'b1;
        else if (clr_ovr)                overrun <= 1'b0;
    end

endmodule

// File: tb/tb_shift_in_deser.sv
module tb_shift_in_deser;

    localparam int NI = 3;
    localparam int WD [NI] = '{8, 8, 12};
    localparam bit LF [NI] = '{1'b1, 1'b0, 1'b1};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic s_in = 1'b0, in_en = 1'b0, sync = 1'b0, out_ready = 1'b0, clr_ovr = 1'b0;

    logic [7:0]  out0, raw0, out1, raw1;
    logic [11:0] out2, raw2;
    logic [2:0]  cnt0, cnt1;
    logic [3:0]  cnt2;
    logic        v0, v1, v2, o0, o1, o2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    shift_in_deser #(.WIDTH(8), .LSB_FIRST(1'b1)) d0 (
        .clk(clk), .rst(rst), .in(s_in), .in_en(in_en), .sync(sync),
        .out(out0), .out_valid(v0), .out_ready(out_ready), .raw(raw0),
        .bit_cnt(cnt0), .overrun(o0), .clr_ovr(clr_ovr));
    shift_in_deser #(.WIDTH(8), .LSB_FIRST(1'b0)) d1 (
        .clk(clk), .rst(rst), .in(s_in), .in_en(in_en), .sync(sync),
        .out(out1), .out_valid(v1), .out_ready(out_ready), .raw(raw1),
        .bit_cnt(cnt1), .overrun(o1), .clr_ovr(clr_ovr));
    shift_in_deser #(.WIDTH(12), .LSB_FIRST(1'b1)) d2 (
        .clk(clk), .rst(rst), .in(s_in), .in_en(in_en), .sync(sync),
        .out(out2), .out_valid(v2), .out_ready(out_ready), .raw(raw2),
        .bit_cnt(cnt2), .overrun(o2), .clr_ovr(clr_ovr));

    // DUT outputs widened to a common shape
    logic [11:0] a_out [NI], a_raw [NI];
    int          a_cnt [NI];
    logic        a_v   [NI], a_o [NI];
    assign a_out[0] = {4'b0, out0}; assign a_raw[0] = {4'b0, raw0};
    assign a_out[1] = {4'b0, out1}; assign a_raw[1] = {4'b0, raw1};
    assign a_out[2] = out2;         assign a_raw[2] = raw2;
    assign a_cnt[0] = int'(cnt0);   assign a_cnt[1] = int'(cnt1);   assign a_cnt[2] = int'(cnt2);
    assign a_v[0] = v0; assign a_v[1] = v1; assign a_v[2] = v2;
    assign a_o[0] = o0; assign a_o[1] = o1; assign a_o[2] = o2;

    // ---------------- reference model ----------------
    // hist holds the received bit history, newest bit at index 0. A word's
    // layout is derived from that history: the i-th newest bit goes to
    // position W-1-i when the first bit lands at bit 0, else to position i.
    function automatic logic [11:0] layout(input logic [11:0] h, input int w, input bit lsbf);
        logic [11:0] r;
        r = '0;
        for (int i = 0; i < w; i++) begin
            if (lsbf) r[w-1-i] = h[i];
            else      r[i]     = h[i];
        end
        return r;
    endfunction

    logic [11:0] hist [NI], m_out [NI];
    int          m_cnt [NI];
    logic        m_v [NI], m_o [NI];

    logic [11:0] h_n [NI], w_n [NI];
    logic        done_n [NI], free_n [NI];

    always_comb begin
        for (int k = 0; k < NI; k++) begin
            h_n[k]    = in_en ? {hist[k][10:0], s_in} : hist[k];
            done_n[k] = in_en && !sync && (m_cnt[k] == WD[k] - 1);
            free_n[k] = !m_v[k] || out_ready;
            w_n[k]    = layout(h_n[k], WD[k], LF[k]);
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NI; k++) begin
                hist[k] <= '0; m_cnt[k] <= 0; m_v[k] <= 1'b0;
                m_out[k] <= '0; m_o[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < NI; k++) begin
                hist[k] <= h_n[k];
                if (sync)       m_cnt[k] <= in_en ? 1 : 0;
                else if (in_en) m_cnt[k] <= (m_cnt[k] + 1) % WD[k];
                if (done_n[k] && free_n[k]) begin
                    m_out[k] <= w_n[k];
                    m_v[k]   <= 1'b1;
                end else if (m_v[k] && out_ready) begin
                    m_v[k] <= 1'b0;
                end
                if (done_n[k] && !free_n[k]) m_o[k] <= 1'b1;
                else if (clr_ovr)           m_o[k] <= 1'b0;
            end
        end
    end

    task automatic chk(input string nm, input int k, input logic [11:0] act, input logic [11:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] got=%h expected=%h t=%0t", nm, k, act, exp, $time);
        end
    endtask

    // compare every cycle, away from the rising edge
    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            chk("raw",       k, a_raw[k], layout(hist[k], WD[k], LF[k]));
            chk("bit_cnt",   k, 12'(a_cnt[k]), 12'(m_cnt[k]));
            chk("out",       k, a_out[k], m_out[k]);
            chk("out_valid", k, 12'(a_v[k]), 12'(m_v[k]));
            chk("overrun",   k, 12'(a_o[k]), 12'(m_o[k]));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input logic b, input logic en, input logic sy, input logic rdy, input logic clr);
        s_in = b; in_en = en; sync = sy; out_ready = rdy; clr_ovr = clr;
        @(posedge clk); #2;
    endtask

    // bit i of v is sent i-th
    task automatic send(input logic [11:0] v, input int n, input logic rdy, input bit gaps);
        for (int i = 0; i < n; i++) begin
            step(v[i], 1'b1, 1'b0, rdy, 1'b0);
            if (gaps) step(1'b0, 1'b0, 1'b0, rdy, 1'b0);
        end
    endtask

    // async reset pulse between edges, with an immediate check of d0
    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_out",  0, a_out[0], 12'h0);
        chk("rst_vld",  0, 12'(a_v[0]), 12'h0);
        chk("rst_raw",  0, a_raw[0], 12'h0);
        chk("rst_cnt",  0, 12'(a_cnt[0]), 12'h0);
        chk("rst_ovr",  0, 12'(a_o[0]), 12'h0);
        #1 rst = 1'b0;
    endtask

    initial begin
        #3;
        chk("init_out", 0, a_out[0], 12'h0);
        chk("init_vld", 0, 12'(a_v[0]), 12'h0);
        #9 rst = 1'b0;
        @(posedge clk); #2;

        // basic: A5 is its own bit-reverse, so both 8-bit orders decode A5
        send(12'h0A5, 8, 1'b1, 1'b0);
        chk("lsb_a5",     0, a_out[0], 12'h0A5);
        chk("lsb_a5_v",   0, 12'(a_v[0]), 12'h1);
        chk("lsb_cnt0",   0, 12'(a_cnt[0]), 12'h0);
        chk("msb_a5",     1, a_out[1], 12'h0A5);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("one_cycle_v", 0, 12'(a_v[0]), 12'h0);

        // MSB-first with gaps
        do_reset();
        send(12'h0A5, 8, 1'b1, 1'b1);
        chk("gap_a5", 1, a_out[1], 12'h0A5);

        // back-pressure and overrun
        do_reset();
        send(12'h03C, 8, 1'b0, 1'b0);
        send(12'h0C3, 8, 1'b0, 1'b0);
        chk("bp_hold", 0, a_out[0], 12'h03C);
        chk("bp_ovr",  0, 12'(a_o[0]), 12'h1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("bp_drain", 0, 12'(a_v[0]), 12'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("bp_clr", 0, 12'(a_o[0]), 12'h0);

        // consume-and-load on the same edge
        do_reset();
        send(12'h011, 8, 1'b0, 1'b0);
        send(12'h022, 7, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("cl_out", 0, a_out[0], 12'h022);
        chk("cl_v",   0, 12'(a_v[0]), 12'h1);
        chk("cl_ovr", 0, 12'(a_o[0]), 12'h0);

        // sync realignment without and with a bit
        do_reset();
        send(12'h005, 3, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("sync_cnt0", 0, 12'(a_cnt[0]), 12'h0);
        chk("sync_raw",  0, a_raw[0], 12'h0A0);
        send(12'h0F0, 8, 1'b1, 1'b0);
        chk("sync_f0", 0, a_out[0], 12'h0F0);
        send(12'h003, 3, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("sync_cnt1", 0, 12'(a_cnt[0]), 12'h1);
        for (int i = 1; i < 8; i++) step(i == 7, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("sync_81", 0, a_out[0], 12'h081);

        // reset mid-word while a word is held, then fresh frames
        send(12'h0FF, 8, 1'b0, 1'b0);
        send(12'h001, 3, 1'b0, 1'b0);
        do_reset();
        send(12'h05A, 8, 1'b1, 1'b0);
        chk("post_rst_5a", 0, a_out[0], 12'h05A);
        do_reset();
        send(12'hABC, 12, 1'b1, 1'b0);
        chk("w12_abc",   2, a_out[2], 12'hABC);
        chk("w12_abc_v", 2, 12'(a_v[2]), 12'h1);

        // randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            step(1'($urandom), $urandom_range(0, 9) < 7, $urandom_range(0, 29) == 0,
                 $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
            if ($urandom_range(0, 399) == 0) begin
                rst = 1'b1;
                #2 rst = 1'b0;
            end
        end

        @(negedge clk); #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
